binary_serial_subtractor: RTL and testbench

//  Bit-serial unsigned subtractor: computes diff = a - b one bit per clock, LSB first, with a

---
 rtl/binary_serial_subtractor_pkg.sv | 12 +
 rtl/binary_serial_subtractor_if.sv | 18 +
 rtl/binary_serial_subtractor_full_subtractor.sv | 13 +
 rtl/binary_serial_subtractor.sv | 95 +++++++++
 tb/tb_binary_serial_subtractor.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/binary_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package binary_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/binary_serial_subtractor_if.sv
// Request/result bundle of the serial subtractor; master issues operands, slave computes.
interface binary_serial_subtractor_if
  import binary_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   diff;

  modport master (output start, a, b, input busy, done, diff);
  modport slave  (input start, a, b, output busy, done, diff);

endinterface

// File: rtl/binary_serial_subtractor_full_subtractor.sv
// One-bit full subtractor: x - y - bin, giving difference bit and borrow-out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/binary_serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, start/busy/done handshake.
module binary_serial_subtractor
  import binary_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  binary_serial_subtractor_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             d_bit;
  logic             borrow_next;
  logic             last_bit;
  logic [WIDTH:0]   diff_q;

  full_subtractor u_slice (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (borrow_next)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Any unused encoding falls back to IDLE so a glitched state register self-recovers.
  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:  state_next = bus.start ? S_RUN : S_IDLE;
      S_RUN:   state_next = last_bit ? S_DONE : S_RUN;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      diff_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            res    <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res    <= {d_bit, res[WIDTH-1:1]};
          borrow <= borrow_next;
          cnt    <= last_bit ? '0 : cnt + 1'b1;
          // The visible result only changes once the final bit is in, never mid-operation.
          if (last_bit) begin
            diff_q <= {borrow_next, d_bit, res[WIDTH-1:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);
  assign bus.diff = diff_q;

endmodule

// File: tb/tb_binary_serial_subtractor.sv
// Self-checking bench for binary_serial_subtractor against an arithmetic reference model.
module tb_binary_serial_subtractor;
  import binary_serial_subtractor_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   passCount  = 0;
  logic [W:0] lastDiff;

  binary_serial_subtractor_if #(.WIDTH(W)) bus ();

  binary_serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected result straight from the arithmetic: sign flag = a<b, low bits = a-b mod 2^W.
  function automatic logic [W:0] refDiff(input int av, input int bv);
    int m;
    m = av - bv;
    if (m < 0) m = m + (1 << W);
    return {logic'(av < bv), m[W-1:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Runs one operation from IDLE and checks busy span, single done pulse, its timing and result.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
    int busyCnt, doneCnt, donePos;
    logic [W:0] doneDiff;
    logic stable;
    busyCnt = 0; doneCnt = 0; donePos = 0; doneDiff = '0; stable = 1'b1;
    bus.a = av; bus.b = bv; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i <= W + 2; i++) begin
      if (bus.busy) busyCnt++;
      if (bus.done) begin
        doneCnt++;
        donePos  = i;
        doneDiff = bus.diff;
      end else if (doneCnt == 0 && bus.diff !== lastDiff) begin
        stable = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput({tag, ".busyCycles"}, busyCnt, W);
    checkOutput({tag, ".doneCount"}, doneCnt, 1);
    checkOutput({tag, ".donePos"}, donePos, W + 1);
    checkOutput({tag, ".diffHeld"}, stable, 1);
    checkOutput({tag, ".diff"}, doneDiff, refDiff(av, bv));
    lastDiff = refDiff(av, bv);
  endtask

  initial begin
    logic [W-1:0] curA, curB, nxtA, nxtB;
    int cyc;
    logic sawDone;

    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lastDiff = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset.busy", bus.busy, 0);
      checkOutput("reset.done", bus.done, 0);
      checkOutput("reset.diff", bus.diff, 0);
    end

    applyStimulus(4'b1010, 4'b0110, "pos");
    applyStimulus(4'b0110, 4'b1010, "neg4");
    applyStimulus(4'b0000, 4'b1111, "neg15");
    applyStimulus(4'b1111, 4'b1111, "eqOnes");
    applyStimulus(4'b0000, 4'b0000, "eqZero");
    applyStimulus(4'b1111, 4'b0000, "max");

    // Reset two cycles into an operation must abort it without a done pulse.
    bus.a = 4'b0011; bus.b = 4'b0101; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstRun.busy", bus.busy, 0);
    checkOutput("rstRun.done", bus.done, 0);
    checkOutput("rstRun.diff", bus.diff, 0);
    @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      if (bus.done || bus.busy) sawDone = 1'b1;
      @(negedge clk);
    end
    checkOutput("rstRun.quiet", sawDone, 0);
    lastDiff = '0;
    applyStimulus(4'b1001, 4'b0011, "afterRst");

    // A start pulse during RUN must neither restart nor queue an operation.
    bus.a = 4'b1010; bus.b = 4'b0110; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.a = 4'b0001; bus.b = 4'b0000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("ignore.doneSeen", bus.done, 1);
    checkOutput("ignore.diff", bus.diff, 5'b00100);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ignore.noRestart", bus.busy, 0);
    lastDiff = 5'b00100;

    // Start held high: consecutive operations with fresh random operands after each accept.
    nxtA = W'($urandom_range(0, (1 << W) - 1));
    nxtB = W'($urandom_range(0, (1 << W) - 1));
    bus.a = nxtA; bus.b = nxtB; bus.start = 1'b1;
    curA = '0; curB = '0;
    for (int op = 0; op < 8; op++) begin
      cyc = 0;
      while (!bus.busy && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      checkOutput("b2b.accept", bus.busy, 1);
      curA = nxtA; curB = nxtB;
      nxtA = W'($urandom_range(0, (1 << W) - 1));
      nxtB = W'($urandom_range(0, (1 << W) - 1));
      bus.a = nxtA; bus.b = nxtB;
      cyc = 0;
      while (!bus.done && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      checkOutput("b2b.diff", bus.diff, refDiff(curA, curB));
    end
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    lastDiff = refDiff(curA, curB);

    for (int ai = 0; ai < (1 << W); ai++) begin
      for (int bi = 0; bi < (1 << W); bi++) begin
        applyStimulus(W'(ai), W'(bi), "exh");
      end
    end

    for (int r = 0; r < 16; r++) begin
      applyStimulus(W'($urandom), W'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
